param_sync_fifo: RTL

//   Parametrised single-clock FIFO; next generation of the 8-bit byte FIFO on the RSA datapath.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_mem_2p.sv | 35 +++
 rtl/param_sync_fifo.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg
//   Shared definitions for the parametrised single-clock FIFO.
//   FIFO_DATA_W_DEF / FIFO_ADDR_W_DEF : default word width and pointer width.
//   fifo_status_t                     : status flag bundle, decoded from the
//                                       registered occupancy count and the
//                                       sticky error flags.
package fifo_pkg;

  localparam int FIFO_DATA_W_DEF = 8;
  localparam int FIFO_ADDR_W_DEF = 3;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_mem_2p.sv
// fifo_mem_2p
//   DEPTH x DATA_W storage array for the FIFO. It has one synchronous write
//   port and one asynchronous read port. Contents are never reset.
// Ports
//   clk    in   1        write clock
//   we     in   1        write enable
//   waddr  in   ADDR_W   write address
//   wdata  in   DATA_W   write data
//   raddr  in   ADDR_W   read address
//   rdata  out  DATA_W   read data, combinational from raddr
module fifo_mem_2p #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// param_sync_fifo
//   Parametrised single-clock FIFO. It buffers operand and ciphertext words
//   between the host/UART side and the modular-exponent core.
//   Build option: define PARAM_SYNC_FIFO_FWFT_EN to select first-word-fall-through
//   reads. When it is undefined, reads are registered with a 1-cycle latency.
// Handshake
//   A push is accepted on a rising edge when wr_en && !full.
//   A pop is accepted on a rising edge when rd_en && !empty.
//   A rejected push sets the sticky overflow flag. A rejected pop sets the
//   sticky underflow flag. flush takes priority over both requests.
//   Standard mode: rd_valid pulses for one cycle after each accepted pop, and
//   rd_data holds that word.
//   FWFT mode: rd_valid = !empty, and rd_data shows the head word. rd_en
//   acknowledges the shown word.
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   flush                synchronous clear of pointers, count and error flags
//   wr_en, wr_data       push request and data
//   rd_en                pop request (acknowledge in FWFT mode)
//   rd_data, rd_valid    popped word and its qualifier
//   full, empty          count == DEPTH / count == 0
//   almost_full          count >= AFULL_TH
//   almost_empty         count <= AEMPTY_TH
//   count                occupancy 0..DEPTH
//   overflow, underflow  sticky error flags
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W    = FIFO_DATA_W_DEF,
  parameter int ADDR_W    = FIFO_ADDR_W_DEF,
  parameter int AFULL_TH  = (1 << ADDR_W) - 1,
  parameter int AEMPTY_TH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int              DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_C   = (ADDR_W + 1)'(AFULL_TH);
  localparam logic [ADDR_W:0] AEMPTY_C  = (ADDR_W + 1)'(AEMPTY_TH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic              overflow_q;
  logic              underflow_q;
  logic [DATA_W-1:0] mem_rdata;
  logic              push_ok;
  logic              pop_ok;
  fifo_status_t      status;

  // Flags come only from registered state, so no request input reaches them combinationally.
  always_comb begin
    status              = '0;
    status.full         = (count_q == DEPTH_C);
    status.empty        = (count_q == '0);
    status.almost_full  = (count_q >= AFULL_C);
    status.almost_empty = (count_q <= AEMPTY_C);
    status.overflow     = overflow_q;
    status.underflow    = underflow_q;
  end

  assign push_ok = wr_en && !status.full;
  assign pop_ok  = rd_en && !status.empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      // Pointers are exactly ADDR_W bits, so they wrap at DEPTH without extra logic.
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (wr_en && status.full)  overflow_q  <= 1'b1;
      if (rd_en && status.empty) underflow_q <= 1'b1;
    end
  end

  fifo_mem_2p #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok && !flush),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

`ifdef PARAM_SYNC_FIFO_FWFT_EN
  // The head word is shown directly. The word is masked to zero while the
  // FIFO is empty, so stale memory never appears on rd_data.
  assign rd_data  = status.empty ? '0 : mem_rdata;
  assign rd_valid = !status.empty;
`else
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else if (flush) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= pop_ok;
      if (pop_ok) rd_data_q <= mem_rdata;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

  assign full         = status.full;
  assign empty        = status.empty;
  assign almost_full  = status.almost_full;
  assign almost_empty = status.almost_empty;
  assign overflow     = status.overflow;
  assign underflow    = status.underflow;
  assign count        = count_q;

endmodule
